sand_ram_write_arbiter: RTL
===========================

// Module: sand_ram_write_arbiter
// PURPOSE
//  Shares one mirrored write port between two requesters: the physics engine and the brush (user-painted sand).
//  The port drives both the game-state RAM and the VRAM, so the two always hold identical contents.
//  Also contains a built-in clear engine that sweeps every pixel to CLEAR_VALUE.
//  Sits in the top level between the requesters and the two RAMs; owns all write enables.
// PARAMETERS
//  ADDR_WIDTH   19      pixel address width
//  DATA_WIDTH   1       pixel data width
//  NUM_PIXELS   307200  pixel count (640*480); legal addresses are 0..NUM_PIXELS-1
//  CLEAR_VALUE  0       value written by the clear sweep
// PORTS
//  clk_i         in   1           system clock
//  reset_i       in   1           asynchronous reset, active-low
//  phys_req_i    in   1           physics write request
//  phys_addr_i   in   ADDR_WIDTH  physics write address
//  phys_data_i   in   DATA_WIDTH  physics write data
//  phys_gnt_o    out  1           physics grant (combinational)
//  brush_req_i   in   1           brush write request
//  brush_addr_i  in   ADDR_WIDTH  brush write address
//  brush_data_i  in   DATA_WIDTH  brush write data
//  brush_gnt_o   out  1           brush grant (combinational)
//  clear_i       in   1           single-cycle clear start pulse
//  clear_busy_o  out  1           high while the clear sweep runs
//  clear_done_o  out  1           1-cycle pulse on the final clear write
//  addr_err_o    out  1           1-cycle pulse: an accepted write was out of range and dropped
//  wr_en_o       out  1           write enable to RAM and VRAM (registered)
//  wr_address_o  out  ADDR_WIDTH  write address (registered)
//  wr_data_o     out  DATA_WIDTH  write data (registered)
// BEHAVIOUR
//  - Reset: every output is 0; FSM=IDLE, sweep counter=0, last_grant=BRUSH (physics wins the first tie).
//    An async assert aborts a sweep in progress. No write is issued after the reset edge.
//  - Handshake: a transfer occurs on a cycle where req && gnt. The requester holds addr/data stable while req && !gnt.
//    At most one grant per cycle. A grant is only ever asserted together with its own req.
//  - Latency: the accepted write appears on wr_* exactly 1 cycle after the handshake.
//    wr_en_o is high for that one cycle only.
//  - FSM IDLE:
//      - Only one requester: grant it.
//      - Both requesting: round-robin, i.e. grant the requester that was not last_grant.
//      - last_grant updates only on a transfer.
//      - clear_i: in that cycle both grants are 0, and the FSM moves to CLEAR on the next edge.
//        clear_i beats any simultaneous request.
//  - FSM CLEAR:
//      - Both grants are held at 0 and clear_busy_o=1.
//      - Each cycle the block writes CLEAR_VALUE at address cnt, then cnt+1.
//        The address sequence is 0..NUM_PIXELS-1, so the sweep lasts exactly NUM_PIXELS cycles.
//      - clear_done_o pulses in the cycle the last write is registered.
//      - The next state is IDLE and cnt resets to 0.
//      - clear_i during CLEAR is ignored (no restart).
//  - Range check:
//      - A transfer with addr >= NUM_PIXELS still completes the handshake (gnt given).
//      - The write is dropped: wr_en_o=0 and addr_err_o=1 on the following cycle.
//  - Widths: cnt is ADDR_WIDTH bits wide; the terminal compare is cnt == NUM_PIXELS-1. There is no wrap past the end.
//  - Requests are never lost: a requester stalled by CLEAR is served once IDLE resumes.
// CONFIGURATION
//  BRUSH_PRIORITY_EN defined:
//    - Fixed priority: brush beats physics whenever both request, and last_grant is unused.
//    - Physics may starve while the brush is held. This is the intended behaviour, for responsive painting.
//  BRUSH_PRIORITY_EN undefined:
//    - Round-robin as described above.
// TESTING
//  1. Reset low mid-stream -> all outputs 0. Release, then phys_req with addr=5, data=1 ->
//     phys_gnt same cycle; next cycle wr_en=1, addr=5, data=1.
//  2. phys and brush both request for 4 cycles (round-robin) ->
//     grants alternate P,B,P,B; the wr_* address sequence matches, each 1 cycle late.
//  3. Same stimulus with BRUSH_PRIORITY_EN defined -> 4 brush grants, 0 physics grants.
//  4. clear_i pulse with both reqs held -> no grants for NUM_PIXELS+1 cycles.
//     Writes cover 0..307199 with data 0, clear_done_o fires once, then phys is granted first.
//  5. brush addr=307200 -> brush_gnt=1; next cycle wr_en=0 and addr_err_o=1.
//  6. Reset asserted at sweep address 1000 -> busy=0 immediately.
//     A new clear_i restarts the sweep from address 0.

Source files
------------

// File: rtl/sand_ram_write_arbiter.sv
// rtl/sand_ram_write_arbiter.sv - mirrored RAM/VRAM write-port arbiter with built-in clear sweep
//
// Purpose:
//   Shares one write port between the physics engine and the brush. The
//   registered wr_* port feeds both the game-state RAM and the VRAM, so both
//   memories always hold identical contents. A clear engine sweeps every
//   pixel address 0..NUM_PIXELS-1 with CLEAR_VALUE.
//
// Ports:
//   clk_i, reset_i                   clock, asynchronous active-low reset
//   phys_req_i/addr_i/data_i         physics write request, phys_gnt_o grant (comb)
//   brush_req_i/addr_i/data_i        brush write request, brush_gnt_o grant (comb)
//   clear_i                          single-cycle clear start pulse
//   clear_busy_o                     high while the sweep runs
//   clear_done_o                     pulse alongside the final sweep write
//   addr_err_o                       pulse: an accepted write was out of range and dropped
//   wr_en_o, wr_address_o, wr_data_o registered write port, 1 cycle after the handshake
//
// Configuration macro:
//   BRUSH_PRIORITY_EN  defined: brush always beats physics on a tie.
//                      undefined: round-robin on a tie.

module sand_ram_write_arbiter #(
  parameter int unsigned           ADDR_WIDTH  = 19,
  parameter int unsigned           DATA_WIDTH  = 1,
  parameter int unsigned           NUM_PIXELS  = 307200,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  phys_req_i,
  input  logic [ADDR_WIDTH-1:0] phys_addr_i,
  input  logic [DATA_WIDTH-1:0] phys_data_i,
  output logic                  phys_gnt_o,
  input  logic                  brush_req_i,
  input  logic [ADDR_WIDTH-1:0] brush_addr_i,
  input  logic [DATA_WIDTH-1:0] brush_data_i,
  output logic                  brush_gnt_o,
  input  logic                  clear_i,
  output logic                  clear_busy_o,
  output logic                  clear_done_o,
  output logic                  addr_err_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_address_o,
  output logic [DATA_WIDTH-1:0] wr_data_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // One extra bit so the range compare also works when NUM_PIXELS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH+1)'(NUM_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
`ifndef BRUSH_PRIORITY_EN
  logic                    last_brush_q, last_brush_d;  // 1: brush was granted last
`endif
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    phys_gnt, brush_gnt;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_data;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
`ifndef BRUSH_PRIORITY_EN
      last_brush_q <= 1'b1;  // physics wins the first tie
`endif
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
`ifndef BRUSH_PRIORITY_EN
      last_brush_q <= last_brush_d;
`endif
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
`ifndef BRUSH_PRIORITY_EN
    last_brush_d = last_brush_q;
`endif
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    phys_gnt     = 1'b0;
    brush_gnt    = 1'b0;
    sel_addr     = '0;
    sel_data     = '0;

    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          // Clear wins over any request; stalled requesters keep asking.
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else begin
`ifdef BRUSH_PRIORITY_EN
          brush_gnt = brush_req_i;
          phys_gnt  = phys_req_i & ~brush_req_i;
`else
          if (phys_req_i && brush_req_i) begin
            phys_gnt  = last_brush_q;
            brush_gnt = ~last_brush_q;
          end else begin
            phys_gnt  = phys_req_i;
            brush_gnt = brush_req_i;
          end
`endif
          if (phys_gnt || brush_gnt) begin
            sel_addr = brush_gnt ? brush_addr_i : phys_addr_i;
            sel_data = brush_gnt ? brush_data_i : phys_data_i;
`ifndef BRUSH_PRIORITY_EN
            last_brush_d = brush_gnt;
`endif
            // Out-of-range writes still complete the handshake but never reach the RAMs.
            if ({1'b0, sel_addr} < PIX_LIMIT) begin
              wr_en_d   = 1'b1;
              wr_addr_d = sel_addr;
              wr_data_d = sel_data;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = CLEAR_VALUE;
        if (cnt_q == LAST_ADDR) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Grants are masked by reset so every output reads 0 while reset is held.
  assign phys_gnt_o   = phys_gnt & reset_i;
  assign brush_gnt_o  = brush_gnt & reset_i;
  assign clear_busy_o = (state_q == ST_CLEAR);
  assign clear_done_o = done_q;
  assign addr_err_o   = err_q;
  assign wr_en_o      = wr_en_q;
  assign wr_address_o = wr_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule
